// File: rtl/xosera_bus_ctrl.sv
// Write sequencer: queues 16-bit register writes and replays each one as two
// byte-wide xosera_main bus cycles with programmable setup/strobe/hold timing.
//
// state  | meaning
// IDLE   | bus released, waiting for a queued word
// SETUP  | reg/bytesel/data driven, strobe not yet asserted
// STROBE | cs_n and rd_nwr low, reg/bytesel/data stable
// HOLD   | strobe released, reg/bytesel/data still held
module xosera_bus_ctrl #(
   parameter int DEPTH      = 4,
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 2,
   parameter int HOLD_CYC   = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [3:0]             req_reg_i,
   input  logic [15:0]            req_data_i,
   output logic                   bus_cs_n_o,
   output logic                   bus_rd_nwr_o,
   output logic [3:0]             bus_reg_num_o,
   output logic                   bus_bytesel_o,
   output logic [7:0]             bus_data_o,
   output logic                   busy_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0]  SETUP_LD  = 4'(SETUP_CYC - 1);
   localparam logic [3:0]  STROBE_LD = 4'(STROBE_CYC - 1);
   localparam logic [3:0]  HOLD_LD   = 4'(HOLD_CYC - 1);
   localparam logic [AW:0] LVL_ONE   = (AW+1)'(1);
   localparam logic [AW:0] LVL_FULL  = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   logic [19:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_next;
   logic [AW:0]   level_q, level_d;
   state_t        state_q, state_d;
   logic          lo_q, lo_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [7:0]    lo_byte_q, lo_byte_d;
   logic          cs_n_q, cs_n_d;
   logic          rd_nwr_q, rd_nwr_d;
   logic [3:0]    reg_num_q, reg_num_d;
   logic          bytesel_q, bytesel_d;
   logic [7:0]    data_q, data_d;
   logic          push, pop, full, empty;
   logic [19:0]   head;

   assign full    = (level_q == LVL_FULL);
   assign empty   = (level_q == '0);
   assign push    = req_valid_i && !full;
   assign rd_next = rd_ptr_q + AW'(1);
   // From IDLE the next word is at the read pointer; when chaining out of the
   // final HOLD the current word is still at the head, so take the one after it.
   assign head    = mem_q[(state_q == IDLE) ? rd_ptr_q : rd_next];

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {req_reg_i, req_data_i};
      end
   end

   always_comb begin
      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + LVL_ONE;
      end else if (!push && pop) begin
         level_d = level_q - LVL_ONE;
      end
   end

   always_comb begin
      state_d   = state_q;
      lo_d      = lo_q;
      cnt_d     = cnt_q;
      lo_byte_d = lo_byte_q;
      reg_num_d = reg_num_q;
      bytesel_d = bytesel_q;
      data_d    = data_q;
      pop       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               state_d   = SETUP;
               cnt_d     = SETUP_LD;
               lo_d      = 1'b0;
               reg_num_d = head[19:16];
               bytesel_d = 1'b0;
               data_d    = head[15:8];
               lo_byte_d = head[7:0];
            end
         end
         SETUP: begin
            if (cnt_q == 4'd0) begin
               state_d = STROBE;
               cnt_d   = STROBE_LD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         STROBE: begin
            if (cnt_q == 4'd0) begin
               state_d = HOLD;
               cnt_d   = HOLD_LD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         HOLD: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (!lo_q) begin
               state_d   = SETUP;
               cnt_d     = SETUP_LD;
               lo_d      = 1'b1;
               bytesel_d = 1'b1;
               data_d    = lo_byte_q;
            end else begin
               pop = 1'b1;
               if (level_q > LVL_ONE) begin
                  state_d   = SETUP;
                  cnt_d     = SETUP_LD;
                  lo_d      = 1'b0;
                  reg_num_d = head[19:16];
                  bytesel_d = 1'b0;
                  data_d    = head[15:8];
                  lo_byte_d = head[7:0];
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      cs_n_d   = (state_d != STROBE);
      rd_nwr_d = cs_n_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         state_q   <= IDLE;
         lo_q      <= 1'b0;
         cnt_q     <= '0;
         lo_byte_q <= '0;
         cs_n_q    <= 1'b1;
         rd_nwr_q  <= 1'b1;
         reg_num_q <= '0;
         bytesel_q <= 1'b0;
         data_q    <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_next;
         end
         level_q   <= level_d;
         state_q   <= state_d;
         lo_q      <= lo_d;
         cnt_q     <= cnt_d;
         lo_byte_q <= lo_byte_d;
         cs_n_q    <= cs_n_d;
         rd_nwr_q  <= rd_nwr_d;
         reg_num_q <= reg_num_d;
         bytesel_q <= bytesel_d;
         data_q    <= data_d;
      end
   end

   assign req_ready_o   = !full;
   assign busy_o        = (state_q != IDLE) || !empty;
   assign level_o       = level_q;
   assign bus_cs_n_o    = cs_n_q;
   assign bus_rd_nwr_o  = rd_nwr_q;
   assign bus_reg_num_o = reg_num_q;
   assign bus_bytesel_o = bytesel_q;
   assign bus_data_o    = data_q;

endmodule

// File: tb/tb_xosera_bus_ctrl.sv
// Bench for xosera_bus_ctrl: two instances (default timing and 3/1/2 timing)
// checked every cycle against a word-schedule model of the queue and bus.
module tb_xosera_bus_ctrl;

   localparam int D    = 4;
   localparam int MAXW = 256;

   typedef struct packed {
      logic [3:0]  r;
      logic [15:0] d;
   } word_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        v0 = 1'b0, v1 = 1'b0;
   logic [3:0]  r0 = '0, r1 = '0;
   logic [15:0] d0 = '0, d1 = '0;
   logic        rdy0, rdy1, cs0, cs1, rw0, rw1, bs0, bs1, busy0, busy1;
   logic [3:0]  rn0, rn1;
   logic [7:0]  bd0, bd1;
   logic [2:0]  lv0, lv1;

   xosera_bus_ctrl u_dut0 (
      .clk(clk), .reset(rst),
      .req_valid_i(v0), .req_ready_o(rdy0), .req_reg_i(r0), .req_data_i(d0),
      .bus_cs_n_o(cs0), .bus_rd_nwr_o(rw0), .bus_reg_num_o(rn0),
      .bus_bytesel_o(bs0), .bus_data_o(bd0), .busy_o(busy0), .level_o(lv0)
   );

   xosera_bus_ctrl #(.DEPTH(4), .SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) u_dut1 (
      .clk(clk), .reset(rst),
      .req_valid_i(v1), .req_ready_o(rdy1), .req_reg_i(r1), .req_data_i(d1),
      .bus_cs_n_o(cs1), .bus_rd_nwr_o(rw1), .bus_reg_num_o(rn1),
      .bus_bytesel_o(bs1), .bus_data_o(bd1), .busy_o(busy1), .level_o(lv1)
   );

   int total = 0;
   int bad   = 0;
   int edge_n = 0;

   // Model: per instance, every accepted word gets a push edge, a start edge
   // (enters SETUP) and a pop edge; the bus waveform follows from the offsets.
   int          m_nw    [2];
   int          m_push  [2][MAXW];
   int          m_start [2][MAXW];
   int          m_pop   [2][MAXW];
   logic [3:0]  m_reg   [2][MAXW];
   logic [15:0] m_data  [2][MAXW];

   word_t offq0[$];
   word_t offq1[$];

   function automatic int su(int i);  return (i == 0) ? 1 : 3; endfunction
   function automatic int st(int i);  return (i == 0) ? 2 : 1; endfunction
   function automatic int ho(int i);  return (i == 0) ? 1 : 2; endfunction
   function automatic int per(int i); return su(i) + st(i) + ho(i); endfunction

   function automatic int mlevel(int i, int n);
      int c = 0;
      for (int k = 0; k < m_nw[i]; k++) begin
         if (m_push[i][k] <= n) c++;
         if (m_pop[i][k] <= n) c--;
      end
      return c;
   endfunction

   function automatic void record(int i, int e, word_t w);
      int n = m_nw[i];
      int s = e + 1;
      if (n > 0 && m_pop[i][n-1] > s) s = m_pop[i][n-1];
      m_push[i][n]  = e;
      m_start[i][n] = s;
      m_pop[i][n]   = s + 2 * per(i);
      m_reg[i][n]   = w.r;
      m_data[i][n]  = w.d;
      m_nw[i]       = n + 1;
   endfunction

   task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s inst%0d edge%0d: got %0h want %0h", tag, i, edge_n, obs, exp);
      end
   endtask

   task automatic check_inst(int i, logic cs, logic rw, logic [3:0] rn, logic bs,
                             logic [7:0] bd, logic rdy, logic busy, logic [2:0] lv);
      int n   = edge_n;
      int lvl = mlevel(i, n);
      int ecs = 1, er = 0, eb = 0, ed = 0;
      for (int k = 0; k < m_nw[i]; k++) begin
         if (m_pop[i][k] <= n) begin
            ecs = 1;
            er  = 32'(m_reg[i][k]);
            eb  = 1;
            ed  = 32'(m_data[i][k][7:0]);
         end else if (m_start[i][k] <= n) begin
            int kk = n - m_start[i][k];
            int j  = kk % per(i);
            eb  = kk / per(i);
            er  = 32'(m_reg[i][k]);
            ed  = (eb == 1) ? 32'(m_data[i][k][7:0]) : 32'(m_data[i][k][15:8]);
            ecs = (j >= su(i) && j < su(i) + st(i)) ? 0 : 1;
         end
      end
      chk("cs_n",    i, 32'(cs),   ecs);
      chk("rd_nwr",  i, 32'(rw),   ecs);
      chk("reg_num", i, 32'(rn),   er);
      chk("bytesel", i, 32'(bs),   eb);
      chk("data",    i, 32'(bd),   ed);
      chk("ready",   i, 32'(rdy),  (lvl < D) ? 1 : 0);
      chk("busy",    i, 32'(busy), (lvl != 0) ? 1 : 0);
      chk("level",   i, 32'(lv),   lvl);
   endtask

   task automatic step();
      word_t w0, w1;
      bit a0 = 1'b0, a1 = 1'b0;
      w0 = '0;
      w1 = '0;
      if (offq0.size() > 0) begin
         w0 = offq0[0]; v0 = 1'b1; r0 = w0.r; d0 = w0.d;
      end else begin
         v0 = 1'b0;
      end
      if (offq1.size() > 0) begin
         w1 = offq1[0]; v1 = 1'b1; r1 = w1.r; d1 = w1.d;
      end else begin
         v1 = 1'b0;
      end
      if (v0 && mlevel(0, edge_n) < D) begin record(0, edge_n + 1, w0); a0 = 1'b1; end
      if (v1 && mlevel(1, edge_n) < D) begin record(1, edge_n + 1, w1); a1 = 1'b1; end
      @(posedge clk);
      edge_n++;
      if (a0) void'(offq0.pop_front());
      if (a1) void'(offq1.pop_front());
      #1;
      check_inst(0, cs0, rw0, rn0, bs0, bd0, rdy0, busy0, lv0);
      check_inst(1, cs1, rw1, rn1, bs1, bd1, rdy1, busy1, lv1);
   endtask

   task automatic model_clear();
      edge_n  = 0;
      m_nw[0] = 0;
      m_nw[1] = 0;
      offq0.delete();
      offq1.delete();
      v0 = 1'b0;
      v1 = 1'b0;
   endtask

   task automatic drain(int budget);
      int left = budget;
      while ((offq0.size() > 0 || offq1.size() > 0 ||
              mlevel(0, edge_n) != 0 || mlevel(1, edge_n) != 0) && left > 0) begin
         step();
         left--;
      end
      if (left == 0) begin
         total++;
         bad++;
         $error("FAIL drain_timeout: got %0d cycles left want >0", left);
      end
      repeat (3) step();
   endtask

   task automatic offer_both(logic [3:0] r, logic [15:0] d);
      word_t w;
      w.r = r;
      w.d = d;
      offq0.push_back(w);
      offq1.push_back(w);
   endtask

   initial begin
      word_t w;
      int idx;

      // reset values
      model_clear();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cs_n",  0, 32'(cs0),  1);
      chk("rst_rdnwr", 0, 32'(rw0),  1);
      chk("rst_reg",   0, 32'(rn0),  0);
      chk("rst_bsel",  0, 32'(bs0),  0);
      chk("rst_data",  0, 32'(bd0),  0);
      chk("rst_ready", 0, 32'(rdy0), 1);
      chk("rst_busy",  0, 32'(busy0), 0);
      chk("rst_level", 0, 32'(lv0),  0);
      chk("rst_cs_n",  1, 32'(cs1),  1);
      chk("rst_level", 1, 32'(lv1),  0);
      rst = 1'b0;

      // single word
      offer_both(4'h3, 16'hA55A);
      drain(100);

      // five words back to back: fills the queue, fifth waits for the first pop
      offer_both(4'h1, 16'h1122);
      offer_both(4'h2, 16'h3344);
      offer_both(4'h7, 16'h5566);
      offer_both(4'hC, 16'h7788);
      offer_both(4'hF, 16'h99AB);
      drain(300);

      // push and pop on the same edge with two words queued
      idx = m_nw[0];
      w.r = 4'h4; w.d = 16'hC0DE; offq0.push_back(w);
      w.r = 4'h5; w.d = 16'hF00D; offq0.push_back(w);
      step();
      step();
      for (int g = 0; g < 50 && edge_n < m_pop[0][idx] - 1; g++) step();
      w.r = 4'h9; w.d = 16'h2468; offq0.push_back(w);
      step();
      chk("pushpop_level", 0, 32'(lv0), 2);
      drain(200);

      // reset in the middle of the high-byte strobe
      offer_both(4'h6, 16'hBEEF);
      step();
      step();
      step();
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_cs_n",  0, 32'(cs0),  1);
      chk("midrst_level", 0, 32'(lv0),  0);
      chk("midrst_ready", 0, 32'(rdy0), 1);
      chk("midrst_cs_n",  1, 32'(cs1),  1);
      chk("midrst_level", 1, 32'(lv1),  0);
      @(posedge clk);
      #1;
      model_clear();
      rst = 1'b0;
      repeat (3) step();
      offer_both(4'h3, 16'hA55A);
      drain(100);

      // randomized traffic with random gaps
      for (int t = 0; t < 400; t++) begin
         w.r = 4'($urandom_range(0, 15));
         w.d = 16'($urandom);
         if ($urandom_range(0, 2) == 0 && offq0.size() < 3) offq0.push_back(w);
         w.r = 4'($urandom_range(0, 15));
         w.d = 16'($urandom);
         if ($urandom_range(0, 3) == 0 && offq1.size() < 3) offq1.push_back(w);
         step();
      end
      drain(400);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/xosera_bus_ctrl.md
# xosera_bus_ctrl

Write sequencer between the CPU's memory-mapped I/O decode and the `xosera_main` 8-bit register bus. It accepts 16-bit register writes (register number + word) through a valid/ready port and queues them in a small FIFO. Each word is replayed as two byte-wide bus cycles with programmable setup, strobe and hold, so the CPU no longer bit-bangs select, data and strobe with separate stores.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `SETUP_CYC`, 1: cycles address/data are valid before the strobe; 1..15.
- `STROBE_CYC`, 2: cycles `bus_cs_n_o` is held low; 1..15.
- `HOLD_CYC`, 1: cycles address/data are held after the strobe; 1..15.

Ports:
- `clk`  in  1  single clock, also the `xosera_main` clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-high; clears the FIFO, FSM and all outputs.
- `req_valid_i`  in  1  write request present.
- `req_ready_o`  out  1  request can be accepted; equals !full.
- `req_reg_i`  in  4  target Xosera register number.
- `req_data_i`  in  16  word to write.
- `bus_cs_n_o`  out  1  Xosera chip select, active-low.
- `bus_rd_nwr_o`  out  1  0 during the strobe, 1 otherwise.
- `bus_reg_num_o`  out  4  register number.
- `bus_bytesel_o`  out  1  0 = high byte [15:8], 1 = low byte [7:0].
- `bus_data_o`  out  8  byte data.
- `busy_o`  out  1  FSM not IDLE, or FIFO not empty.
- `level_o`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Push happens when `req_valid_i && req_ready_o` at a rising edge. The entry {reg, data} is written and `level_o` increments.
- When the FIFO is full, `req_ready_o`=0. A pop in the same cycle does not re-enable the push; ready updates the following cycle.
- The FSM has four states: IDLE, SETUP, STROBE, HOLD. It also keeps a byte flag `lo` (0 = high byte) and a 4-bit phase counter.
- IDLE → SETUP when the FIFO is not empty. The head entry is latched, `lo`=0, and the bus drives reg, `bytesel`=0, data[15:8], with `cs_n`=1 and `rd_nwr`=1.
- SETUP lasts SETUP_CYC cycles, then the FSM goes to STROBE.
- STROBE lasts STROBE_CYC cycles with `cs_n`=0 and `rd_nwr`=0. Reg, bytesel and data are stable throughout.
- HOLD lasts HOLD_CYC cycles with `cs_n`=1 and `rd_nwr`=1. Reg, bytesel and data are still held.
- At the end of HOLD with `lo`=0: go to SETUP, set `lo`=1, and drive `bytesel`=1 and data[7:0]. The register number is unchanged.
- At the end of HOLD with `lo`=1: pop the entry and decrement `level_o`.
  - If another entry is available, go directly to SETUP for the next entry, with no IDLE cycle.
  - Otherwise, go to IDLE.
- All bus outputs are registered. In IDLE, bus outputs hold their last value, except `cs_n`=1 and `rd_nwr`=1.
- A push and a pop in the same cycle leave `level_o` unchanged.
- Entries are never reordered or dropped. A write is never split across entries.

## Timing
- Reset values:
  - `bus_cs_n_o`=1, `bus_rd_nwr_o`=1.
  - `bus_reg_num_o`=0, `bus_bytesel_o`=0, `bus_data_o`=0.
  - `req_ready_o`=1, `busy_o`=0, `level_o`=0.
  - FSM in IDLE, FIFO pointers 0.
- Latency: push at edge E0 → FSM in SETUP with high-byte address/data after E1 → first `cs_n` low after E1+SETUP_CYC.
- One word occupies 2·(SETUP_CYC+STROBE_CYC+HOLD_CYC) cycles; 8 cycles at the defaults.
- Sustained throughput is one word per 8 cycles at the defaults, with no gaps between queued words.
- `busy_o` goes high the cycle after the push. It falls the cycle after the final HOLD when the FIFO is empty.
- Asserting reset mid-transfer immediately forces `cs_n`=1 and empties the FIFO. A partially written word is abandoned and the remaining byte is not sent.
- FIFO pointers wrap modulo DEPTH. Full/empty are derived from `level_o`.

## Test plan
- Reset, then a single push {reg=4'h3, data=16'hA55A} → after the push edge, 1 setup, 2 strobe cycles (`bytesel`=0, data 8'hA5), 1 hold, then 1 setup, 2 strobe cycles (`bytesel`=1, data 8'h5A), 1 hold, then IDLE. The 8 cycles are counted from the first SETUP. `busy_o` is 0 afterwards.
- Push 4 words back-to-back with `req_valid_i` held high → `req_ready_o` drops after the 4th push. Exactly 8 strobes appear, spaced without IDLE cycles, in order, with correct reg/bytesel/data.
- A 5th request held while full → accepted in the cycle after the first pop. `level_o` sequence 4→3→4, and the data is emitted last.
- Push and pop in the same cycle with `level_o`=2 → `level_o` stays 2 and the FIFO contents are intact.
- Assert `reset` during the high-byte STROBE of a word → `bus_cs_n_o`=1 asynchronously, `level_o`=0, no low-byte cycle. A subsequent push behaves exactly as the first scenario.
- Parameters SETUP_CYC=3, STROBE_CYC=1, HOLD_CYC=2 → each byte cycle spans 6 cycles and `cs_n` is low for exactly 1 cycle. Data is stable from 3 cycles before to 2 cycles after the strobe.
